// File: rtl/clocked_video_tpg.sv
// rtl/clocked_video_tpg.sv - free-running clocked-video test pattern generator
module clocked_video_tpg #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [23:0] vid_data,
  output logic        vid_datavalid,
  output logic        vid_h_sync,
  output logic        vid_v_sync,
  output logic        vid_f,
  output logic        vid_locked
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are wide enough to also hold H_TOTAL/V_TOTAL so that the
  // exclusive sync-end bounds below always fit.
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int BAR_W   = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_LAST  = HW'(BAR_W - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q;
  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;
  logic [2:0]    bar_q;
  logic [HW-1:0] inbar_q;
  logic [1:0]    pat_q;
  logic [7:0]    frame_cnt_q;

  logic [23:0]   data_q;
  logic          de_q;
  logic          hs_q;
  logic          vs_q;
  logic          locked_q;

  logic          h_last;
  logic          v_last;
  logic          active;
  logic [23:0]   bar_rgb;
  logic [23:0]   pat_rgb;
  logic [23:0]   data_d;
  logic          de_d;
  logic          hs_d;
  logic          vs_d;

  // Decode the pixel at the current counter position into next output values
  always_comb begin
    h_last = (h_cnt_q == H_LAST);
    v_last = (v_cnt_q == V_LAST);
    active = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs_d   = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : !SYNC_POL;
    vs_d   = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : !SYNC_POL;

    bar_rgb = 24'h000000;
    case (bar_q)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
    endcase

    pat_rgb = bar_rgb;
    case (pat_q)
      2'd0:    pat_rgb = bar_rgb;
      2'd1:    pat_rgb = {3{8'(h_cnt_q)}};
      2'd2:    pat_rgb = (|((8'(h_cnt_q) ^ 8'(v_cnt_q)) & 8'h08)) ? 24'hFFFFFF : 24'h000000;
      default: pat_rgb = {3{frame_cnt_q}};
    endcase

    data_d = active ? pat_rgb : 24'h000000;
    de_d   = active;
  end

  // Run/idle state machine: raster counters, bar tracking and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      bar_q       <= '0;
      inbar_q     <= '0;
      pat_q       <= '0;
      frame_cnt_q <= '0;
      data_q      <= '0;
      de_q        <= 1'b0;
      hs_q        <= !SYNC_POL;
      vs_q        <= !SYNC_POL;
      locked_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          h_cnt_q  <= '0;
          v_cnt_q  <= '0;
          bar_q    <= '0;
          inbar_q  <= '0;
          data_q   <= '0;
          de_q     <= 1'b0;
          hs_q     <= !SYNC_POL;
          vs_q     <= !SYNC_POL;
          locked_q <= 1'b0;
          if (enable) begin
            state_q <= S_RUN;
            pat_q   <= pattern_sel;
          end
        end
        S_RUN: begin
          data_q <= data_d;
          de_q   <= de_d;
          hs_q   <= hs_d;
          vs_q   <= vs_d;
          if (h_last) begin
            h_cnt_q <= '0;
            bar_q   <= '0;
            inbar_q <= '0;
            v_cnt_q <= v_last ? '0 : v_cnt_q + VW'(1);
          end else begin
            h_cnt_q <= h_cnt_q + HW'(1);
            // Bar index advances every BAR_W pixels and sticks at the last bar
            if (inbar_q == BAR_LAST) begin
              inbar_q <= '0;
              if (bar_q != 3'd7) bar_q <= bar_q + 3'd1;
            end else begin
              inbar_q <= inbar_q + HW'(1);
            end
          end
          if (h_last && v_last) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            if (enable) begin
              pat_q    <= pattern_sel;
              locked_q <= 1'b1;
            end else begin
              state_q  <= S_IDLE;
              locked_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign vid_data      = data_q;
  assign vid_datavalid = de_q;
  assign vid_h_sync    = hs_q;
  assign vid_v_sync    = vs_q;
  assign vid_f         = 1'b0;
  assign vid_locked    = locked_q;

endmodule
